// File: rtl/fir_output_decimator.sv
// ----------------------------------------------------------------------------
// fir_output_decimator
//
// Post-processing stage for the symmetric broadcast FIR. It discards the
// pipeline-fill samples and decimates by DECIM. Each kept sample is rounded
// (half-up) and shifted right by SHIFT, then saturated to 16-bit signed. The
// results are buffered in a small FIFO toward a valid/ready consumer. The
// filter is free-running, so a stalled consumer can only cause drops, and
// each drop is flagged by `overflow`.
//
// Parameters:
//   FILTER_SIZE - filter tap count; warm-up is FILTER_SIZE+1 enabled cycles
//   DECIM       - decimation factor (>=1)
//   SHIFT       - arithmetic right shift before saturation (0..8)
//   FIFO_DEPTH  - output FIFO entries (power of two, >=2)
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high
//   en         - filter enable, qualifies data_in
//   data_in    - 24-bit signed FIR accumulator output
//   out_data   - 16-bit signed FIFO head (0 while empty)
//   out_valid  - FIFO not empty
//   out_ready  - consumer pops the head when out_valid is also high
//   fifo_level - FIFO occupancy
//   overflow   - sticky, a kept sample was dropped on a full FIFO
//   sat_flag   - sticky, a kept sample saturated
// ----------------------------------------------------------------------------
module fir_output_decimator #(
    parameter  int FILTER_SIZE = 172,
    parameter  int DECIM       = 2,
    parameter  int SHIFT       = 4,
    parameter  int FIFO_DEPTH  = 8,
    localparam int LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [23:0]      data_in,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic             sat_flag
);

    localparam int WARMUP = FILTER_SIZE + 1;
    localparam int WU_W   = $clog2(WARMUP + 1);
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    // Half of one output LSB, or zero when no shift is applied.
    localparam logic signed [24:0] RND = 25'((1 << SHIFT) >> 1);

    // Warm-up and decimation state
    logic [WU_W-1:0]   warm_q, warm_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic              warmed, keep;

    // Round / saturate stage
    logic signed [24:0] data_sx, sum, t;
    logic               sat_hi, sat_lo;
    logic [15:0]        rounded;
    logic               stage_valid_q, stage_valid_d;
    logic [15:0]        stage_data_q, stage_data_d;
    logic               sat_q, sat_d;

    // FIFO
    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              full, pop, push, drop;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        warm_d = warm_q;
        ph_d   = ph_q;

        warmed = (warm_q == WU_W'(WARMUP));
        keep   = en && warmed && (ph_q == '0);

        if (en && !warmed) begin
            warm_d = warm_q + 1'b1;
        end
        // The phase only runs once warm-up is over. Phase 0 is the kept
        // slot, so the first post-warm-up sample is always kept.
        if (en && warmed) begin
            ph_d = (ph_q == PH_W'(DECIM - 1)) ? '0 : ph_q + 1'b1;
        end
    end

    always_comb begin
        data_sx = {data_in[23], data_in};
        sum     = data_sx + RND;
        t       = sum >>> SHIFT;
        sat_hi  = (t > 25'sd32767);
        sat_lo  = (t < -25'sd32768);
        rounded = t[15:0];
        if (sat_hi) begin
            rounded = 16'h7FFF;
        end else if (sat_lo) begin
            rounded = 16'h8000;
        end

        stage_valid_d = keep;
        stage_data_d  = keep ? rounded : stage_data_q;
        sat_d         = sat_q | (keep & (sat_hi | sat_lo));
    end

    always_comb begin
        full = (level_q == LVL_W'(FIFO_DEPTH));
        pop  = (level_q != '0) && out_ready;
        // On a full FIFO a write is accepted only if the same edge pops.
        // The write then lands in the slot that the pop frees.
        push = stage_valid_q && (!full || pop);
        drop = stage_valid_q && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        ovf_d = ovf_q | drop;
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q        <= '0;
            ph_q          <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            sat_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            ovf_q         <= 1'b0;
        end else begin
            warm_q        <= warm_d;
            ph_q          <= ph_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            sat_q         <= sat_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            ovf_q         <= ovf_d;
        end
    end

    // NOTE: the storage array has no reset. Only slots below the level are
    // ever observed, and the output is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= stage_data_q;
        end
    end

    // All outputs come from registers only. out_ready has no combinational
    // path to them.
    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem[rd_ptr_q] : 16'h0000;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
module tb_fir_output_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance A: FILTER_SIZE=4, DECIM=2, SHIFT=0 ----------
    logic        rst_a, en_a, rdy_a;
    logic [23:0] din_a;
    logic [15:0] dout_a;
    logic        vld_a, ovf_a, sat_a;
    logic [3:0]  lvl_a;

    fir_output_decimator #(.FILTER_SIZE(4), .DECIM(2), .SHIFT(0), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .data_in(din_a),
        .out_data(dout_a), .out_valid(vld_a), .out_ready(rdy_a),
        .fifo_level(lvl_a), .overflow(ovf_a), .sat_flag(sat_a)
    );

    // ---------------- instance B: FILTER_SIZE=1, DECIM=1, SHIFT=4 ----------
    logic        rst_b, en_b, rdy_b;
    logic [23:0] din_b;
    logic [15:0] dout_b;
    logic        vld_b, ovf_b, sat_b;
    logic [3:0]  lvl_b;

    fir_output_decimator #(.FILTER_SIZE(1), .DECIM(1), .SHIFT(4), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .data_in(din_b),
        .out_data(dout_b), .out_valid(vld_b), .out_ready(rdy_b),
        .fifo_level(lvl_b), .overflow(ovf_b), .sat_flag(sat_b)
    );

    logic [15:0] got[$];
    logic        collect_a = 1'b0;
    logic        collect_b = 1'b0;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    // While collecting with ready high, each valid head seen here is popped on
    // the next edge, so every sample is a distinct entry.
    task automatic step_a(input logic e, input logic [23:0] d);
        en_a  = e;
        din_a = d;
        @(posedge clk);
        #1;
        if (collect_a && vld_a && rdy_a) got.push_back(dout_a);
    endtask

    task automatic step_b(input logic e, input logic [23:0] d);
        en_b  = e;
        din_b = d;
        @(posedge clk);
        #1;
        if (collect_b && vld_b && rdy_b) got.push_back(dout_b);
    endtask

    // With ready high, pop instance A until it is empty (bounded).
    task automatic drain_a(input string name);
        int n;
        n = 0;
        rdy_a = 1'b1;
        collect_a = 1'b0;
        while (vld_a && n < 20) begin
            got.push_back(dout_a);
            step_a(1'b0, 24'd0);
            n++;
        end
        if (vld_a) check({name, "_drain_timeout"}, 32'(vld_a), 32'd0);
    endtask

    typedef struct {
        logic [23:0] din;
        logic [15:0] exp_data;
        logic        exp_sat;
    } rnd_vec_t;

    initial begin
        rnd_vec_t vecs[10];
        logic [15:0] exp_q[$];

        vecs[0] = '{24'h000018, 16'h0002, 1'b0};
        vecs[1] = '{24'h000017, 16'h0001, 1'b0};
        vecs[2] = '{24'hFFFFE8, 16'hFFFF, 1'b0};
        vecs[3] = '{24'h000008, 16'h0001, 1'b0};
        vecs[4] = '{24'h000007, 16'h0000, 1'b0};
        vecs[5] = '{24'h07FFF7, 16'h7FFF, 1'b0};
        vecs[6] = '{24'hF80000, 16'h8000, 1'b0};
        vecs[7] = '{24'h07FFF8, 16'h7FFF, 1'b1};
        vecs[8] = '{24'h7FFFFF, 16'h7FFF, 1'b1};
        vecs[9] = '{24'h800000, 16'h8000, 1'b1};

        rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b1; din_a = '0;
        rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b1; din_b = '0;
        step_a(1'b0, 24'd0);
        step_a(1'b0, 24'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // ---- reset state ----
        check("rst_valid", 32'(vld_a), 32'd0);
        check("rst_level", 32'(lvl_a), 32'd0);
        check("rst_data",  32'(dout_a), 32'd0);
        check("rst_ovf",   32'(ovf_a), 32'd0);
        check("rst_sat",   32'(sat_a), 32'd0);

        // ---- warm-up and decimation: data_in = n on enabled cycle n ----
        got.delete();
        collect_a = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            step_a(1'b1, 24'(n));
            if (n == 5) check("lat_not_yet", 32'(vld_a), 32'd0);
            if (n == 6) begin
                check("lat_valid", 32'(vld_a), 32'd1);
                check("lat_data",  32'(dout_a), 32'd5);
            end
        end
        for (int i = 0; i < 6; i++) step_a(1'b0, 24'd0);
        collect_a = 1'b0;
        check("dec_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            check($sformatf("dec_out%0d", i), 32'(got[i]), 32'(5 + 2 * i));
        check("dec_ovf", 32'(ovf_a), 32'd0);

        // ---- back-pressure and overflow: kept samples 1..10, ready low ----
        rdy_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step_a(1'b1, 24'(k));
            step_a(1'b1, 24'd999);
            check($sformatf("bp_level%0d", k), 32'(lvl_a), 32'((k > 8) ? 8 : k));
            check($sformatf("bp_ovf%0d", k), 32'(ovf_a), 32'(k > 8));
        end
        got.delete();
        drain_a("bp");
        check("bp_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            check($sformatf("bp_out%0d", i), 32'(got[i]), 32'(i + 1));

        // ---- reset mid-stream: 5 queued, both sticky flags set ----
        rdy_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step_a(1'b1, (k == 0) ? 24'h100000 : 24'(k + 1));
            step_a(1'b1, 24'd999);
        end
        check("mid_level", 32'(lvl_a), 32'd5);
        check("mid_sat",   32'(sat_a), 32'd1);
        check("mid_ovf",   32'(ovf_a), 32'd1);
        rst_a = 1'b1;
        rdy_a = 1'b1;
        step_a(1'b1, 24'd7);
        rst_a = 1'b0;
        check("mrst_valid", 32'(vld_a), 32'd0);
        check("mrst_level", 32'(lvl_a), 32'd0);
        check("mrst_ovf",   32'(ovf_a), 32'd0);
        check("mrst_sat",   32'(sat_a), 32'd0);
        for (int n = 0; n <= 6; n++) begin
            step_a(1'b1, 24'(100 + n));
            if (n <= 5) check($sformatf("mrst_warm%0d", n), 32'(vld_a), 32'd0);
        end
        check("mrst_first_valid", 32'(vld_a), 32'd1);
        check("mrst_first_data",  32'(dout_a), 32'd105);
        got.delete();
        drain_a("mrst");

        // ---- full FIFO with simultaneous pop ----
        rdy_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step_a(1'b1, 24'(200 + k));
            step_a(1'b1, 24'd999);
        end
        check("full_level", 32'(lvl_a), 32'd8);
        step_a(1'b1, 24'd300);          // kept, waits in the stage register
        check("full_head", 32'(dout_a), 32'd200);
        rdy_a = 1'b1;
        step_a(1'b0, 24'd0);            // write and pop on the same edge
        check("fullpop_level", 32'(lvl_a), 32'd8);
        check("fullpop_ovf",   32'(ovf_a), 32'd0);
        got.delete();
        drain_a("fullpop");
        exp_q = '{16'd201, 16'd202, 16'd203, 16'd204, 16'd205, 16'd206, 16'd207, 16'd300};
        check("fullpop_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            check($sformatf("fullpop_out%0d", i), 32'(got[i]), 32'(exp_q[i]));

        // ---- en gaps: phase is 1 here; en pattern 1,0,0,1 repeated ----
        got.delete();
        collect_a = 1'b1;
        for (int i = 0; i < 12; i++)
            step_a((i % 4 == 0 || i % 4 == 3) ? 1'b1 : 1'b0, 24'(400 + i));
        for (int i = 0; i < 4; i++) step_a(1'b0, 24'd0);
        collect_a = 1'b0;
        exp_q = '{16'd403, 16'd407, 16'd411};
        check("gap_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check($sformatf("gap_out%0d", i), 32'(got[i]), 32'(exp_q[i]));

        // ---- rounding and saturation (instance B, warm-up = 2) ----
        step_b(1'b1, 24'h123456);
        step_b(1'b1, 24'h123456);
        check("rnd_warm_valid", 32'(vld_b), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step_b(1'b1, vecs[i].din);
            step_b(1'b0, 24'd0);
            check($sformatf("rnd_valid%0d", i), 32'(vld_b), 32'd1);
            check($sformatf("rnd_data%0d", i), 32'(dout_b), 32'(vecs[i].exp_data));
            check($sformatf("rnd_sat%0d", i), 32'(sat_b), 32'(vecs[i].exp_sat));
        end

        // ---- sustained throughput, DECIM=1, ready high ----
        step_b(1'b0, 24'd0);
        got.delete();
        collect_b = 1'b1;
        for (int i = 0; i < 10; i++) step_b(1'b1, 24'(16 * i));
        for (int i = 0; i < 4; i++) step_b(1'b0, 24'd0);
        collect_b = 1'b0;
        check("thr_count", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++)
            check($sformatf("thr_out%0d", i), 32'(got[i]), 32'(i));
        check("thr_ovf", 32'(ovf_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
